// File: rtl/rx_phase_ctrl.sv
// rx_phase_ctrl: picks the matched-filter sampling phase with the largest |x| energy.
// Optional RX_PHASE_CTRL_TRACK_EN: continuous re-measurement after the first decision.
module rx_phase_ctrl #(
    parameter  int UPSAMPLE   = 4,
    parameter  int DATA_NBITS = 8,
    parameter  int WIN_LOG2   = 10,
    localparam int ACC_NBITS  = DATA_NBITS + WIN_LOG2,
    localparam int PH_NBITS   = $clog2(UPSAMPLE)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         start,
    input  logic signed [DATA_NBITS-1:0] sample_in,
    output logic        [PH_NBITS-1:0]   phase_out,
    output logic                         locked,
    output logic                         busy,
    output logic                         done,
    output logic        [ACC_NBITS-1:0]  energy_max
);

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        DECIDE,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [UPSAMPLE-1:0][ACC_NBITS-1:0] acc;
    logic [PH_NBITS-1:0]                phase_cnt;
    logic [WIN_LOG2-1:0]                sym_cnt;
    logic [PH_NBITS-1:0]                best_idx;
    logic [ACC_NBITS-1:0]               best_val;

    logic                  clr;
    logic                  acc_en;
    logic                  scan_en;
    logic                  load;
    logic                  phase_last;
    logic                  win_last;
    logic [DATA_NBITS-1:0] neg_val;
    logic [DATA_NBITS-1:0] abs_val;
    logic [ACC_NBITS:0]    acc_sum;
    logic [ACC_NBITS-1:0]  acc_sat;
    logic                  scan_gt;
    logic [PH_NBITS-1:0]   scan_idx;
    logic [ACC_NBITS-1:0]  scan_val;

    // Magnitude taken as unsigned so the most negative code maps to 2^(N-1)
    assign neg_val  = $unsigned(-sample_in);
    assign abs_val  = sample_in[DATA_NBITS-1] ? neg_val : $unsigned(sample_in);
    assign acc_sum  = {1'b0, acc[phase_cnt]} + {{(WIN_LOG2 + 1){1'b0}}, abs_val};
    assign acc_sat  = acc_sum[ACC_NBITS] ? {ACC_NBITS{1'b1}} : acc_sum[ACC_NBITS-1:0];

    assign phase_last = (phase_cnt == PH_NBITS'(UPSAMPLE - 1));
    assign win_last   = (sym_cnt == {WIN_LOG2{1'b1}});

    // Strict compare: on a tie the earlier (lower) phase is kept
    assign scan_gt  = (acc[phase_cnt] > best_val);
    assign scan_idx = scan_gt ? phase_cnt : best_idx;
    assign scan_val = scan_gt ? acc[phase_cnt] : best_val;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        acc_en    = 1'b0;
        scan_en   = 1'b0;
        load      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = MEASURE;
                    clr       = 1'b1;
                end
            end
            MEASURE: begin
                if (enable) begin
                    acc_en = 1'b1;
                    if (phase_last && win_last) begin
                        state_nxt = DECIDE;
                    end
                end
            end
            DECIDE: begin
                scan_en = 1'b1;
                if (phase_last) begin
                    load      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
`ifdef RX_PHASE_CTRL_TRACK_EN
                state_nxt = MEASURE;
                clr       = 1'b1;
`else
                state_nxt = IDLE;
`endif
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Accumulators, phase/symbol counters and the running maximum
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            phase_cnt <= '0;
            sym_cnt   <= '0;
            best_idx  <= '0;
            best_val  <= '0;
        end else if (clr) begin
            acc       <= '0;
            phase_cnt <= '0;
            sym_cnt   <= '0;
            best_idx  <= '0;
            best_val  <= '0;
        end else if (acc_en) begin
            acc[phase_cnt] <= acc_sat;
            phase_cnt      <= phase_cnt + PH_NBITS'(1);
            if (phase_last) begin
                sym_cnt <= sym_cnt + WIN_LOG2'(1);
            end
        end else if (scan_en) begin
            phase_cnt <= phase_cnt + PH_NBITS'(1);
            best_idx  <= scan_idx;
            best_val  <= scan_val;
        end
    end

    // Registered outputs; the final compare result lands as DONE begins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_out  <= '0;
            energy_max <= '0;
            locked     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            busy <= (state_nxt == MEASURE) || (state_nxt == DECIDE);
            done <= load;
            if (load) begin
                phase_out  <= scan_idx;
                energy_max <= scan_val;
                locked     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rx_phase_ctrl.sv
// tb_rx_phase_ctrl: vector table, corner sequences and randomized runs.
// Expected results come from per-phase sums computed over the stimulus queues.
module tb_rx_phase_ctrl;

    localparam int U    = 4;
    localparam int DN   = 8;
    localparam int WL   = 4;
    localparam int AN   = DN + WL;
    localparam int PN   = 2;
    localparam int NS   = U * (1 << WL);
    localparam int AMAX = (1 << AN) - 1;
`ifdef RX_PHASE_CTRL_TRACK_EN
    localparam int TRACK = 1;
`else
    localparam int TRACK = 0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 enable = 1'b0;
    logic                 start = 1'b0;
    logic signed [DN-1:0] sample_in = '0;
    logic [PN-1:0]        phase_out;
    logic                 locked;
    logic                 busy;
    logic                 done;
    logic [AN-1:0]        energy_max;

    rx_phase_ctrl #(
        .UPSAMPLE  (U),
        .DATA_NBITS(DN),
        .WIN_LOG2  (WL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .start     (start),
        .sample_in (sample_in),
        .phase_out (phase_out),
        .locked    (locked),
        .busy      (busy),
        .done      (done),
        .energy_max(energy_max)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    p0, p1, p2, p3;
        int    mode;
        int    ph;
        int    en;
        int    cyc;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int cyc;
    int force_cyc = 0;
    bit en_q[$];
    int smp_q[$];
    int start_extra[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_phase"},  64'(phase_out),  0);
        chk({nm, "_locked"}, 64'(locked),     0);
        chk({nm, "_busy"},   64'(busy),       0);
        chk({nm, "_done"},   64'(done),       0);
        chk({nm, "_energy"}, 64'(energy_max), 0);
    endtask

    // mode 0: always enabled, 1: enabled on odd cycles, 2: random gaps and data
    task automatic build(input int p0, input int p1, input int p2, input int p3,
                         input int mode, input int n);
        int pat[4];
        int k;
        bit e;
        pat = '{p0, p1, p2, p3};
        k = 0;
        en_q.delete();
        smp_q.delete();
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       e = 1'b1;
                1:       e = i[0];
                default: e = ($urandom_range(0, 3) != 0);
            endcase
            en_q.push_back(e);
            if (e && mode != 2) begin
                smp_q.push_back(pat[k % 4]);
                k++;
            end else begin
                smp_q.push_back(int'($urandom_range(0, 255)) - 128);
            end
        end
    endtask

    task automatic model(output int ph, output int en, output int cexp);
        int acc[U];
        int k;
        int a;
        k = 0;
        cexp = -1;
        for (int p = 0; p < U; p++) acc[p] = 0;
        for (int i = 0; i < en_q.size(); i++) begin
            if (en_q[i] && k < NS) begin
                a = (smp_q[i] < 0) ? -smp_q[i] : smp_q[i];
                acc[k % U] = acc[k % U] + a;
                if (acc[k % U] > AMAX) acc[k % U] = AMAX;
                k++;
                if (k == NS) cexp = i + 2 + U + 1;
            end
        end
        ph = 0;
        en = acc[0];
        for (int p = 1; p < U; p++) begin
            if (acc[p] > en) begin
                ph = p;
                en = acc[p];
            end
        end
    endtask

    task automatic drive(input int c);
        int idx;
        logic s;
        s = (c == 1);
        foreach (start_extra[j]) if (start_extra[j] == c) s = 1'b1;
        start = s;
        idx = c - 2;
        if (idx >= 0 && idx < en_q.size()) begin
            enable    = en_q[idx];
            sample_in = DN'(smp_q[idx]);
        end else begin
            enable    = 1'b0;
            sample_in = '0;
        end
    endtask

    task automatic wait_done(input string nm, input int limit, output int dcyc);
        dcyc = -1;
        while (cyc < limit && dcyc < 0) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) chk({nm, "_busy_meas"}, 64'(busy), 1);
            if (done === 1'b1) dcyc = cyc;
            drive(cyc);
            if (cyc == force_cyc) begin
                force dut.acc = {AN'(0), AN'(0), AN'(4000), AN'(0)};
                #1;
                release dut.acc;
            end
        end
        if (dcyc < 0) chk({nm, "_timeout"}, 64'(done), 1);
    endtask

    task automatic run_check(input string nm, input int ph, input int en,
                             input int ce, input int limit);
        int dc;
        cyc = 1;
        drive(1);
        wait_done(nm, limit, dc);
        chk({nm, "_cycle"},  64'(dc),         64'(ce));
        chk({nm, "_phase"},  64'(phase_out),  64'(ph));
        chk({nm, "_energy"}, 64'(energy_max), 64'(en));
        chk({nm, "_locked"}, 64'(locked),     1);
        @(negedge clk);
        cyc++;
        chk({nm, "_pulse"},  64'(done), 0);
        chk({nm, "_after"},  64'(busy), 64'(TRACK));
        drive(cyc);
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        start  = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        vec_t vt[4];
        int   ph, en, ce, dc;

        vt[0] = '{"phase2",  10,  20, 100,  20, 0, 2, 1600,  70};
        vt[1] = '{"tie",     50,  50, -50, -50, 0, 0,  800,  70};
        vt[2] = '{"extreme", -128, 0,   0,   0, 1, 0, 2048, 134};
        vt[3] = '{"phase3",   0,   0,   0,  90, 0, 3, 1440,  70};

        @(negedge clk);
        chk_zero("por");
        rst = 1'b1;
        @(negedge clk);

        foreach (vt[i]) begin
            do_reset();
            build(vt[i].p0, vt[i].p1, vt[i].p2, vt[i].p3, vt[i].mode, 200);
            run_check(vt[i].name, vt[i].ph, vt[i].en, vt[i].cyc, 300);
        end

        // Reset in the middle of a window, then a clean window from zero
        do_reset();
        build(10, 20, 100, 20, 0, 200);
        cyc = 1;
        drive(1);
        repeat (19) begin
            @(negedge clk);
            cyc++;
            drive(cyc);
        end
        rst    = 1'b0;
        start  = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        chk_zero("midrst");
        rst = 1'b1;
        build(10, 20, 100, 20, 0, 200);
        run_check("postrst", 2, 1600, 70, 300);

        // Start pulses while busy and in DONE must not restart anything
        do_reset();
        build(10, 20, 100, 20, 0, 200);
        start_extra = '{5, 30, 70};
        run_check("startign", 2, 1600, 70, 300);
        @(negedge clk);
        cyc++;
        chk("startign_busy2", 64'(busy), 64'(TRACK));
        drive(cyc);
        start_extra.delete();

        // Accumulator pushed near full scale must clamp, not wrap
        do_reset();
        build(0, 127, 0, 0, 0, 200);
        force_cyc = 10;
        run_check("sat", 1, AMAX, 70, 300);
        force_cyc = 0;

        for (int r = 0; r < 4; r++) begin
            do_reset();
            build(0, 0, 0, 0, 2, 300);
            model(ph, en, ce);
            run_check($sformatf("rand%0d", r), ph, en, ce, 400);
        end

`ifdef RX_PHASE_CTRL_TRACK_EN
        // Continuous tracking follows a pattern change into the next window
        do_reset();
        en_q.delete();
        smp_q.delete();
        for (int i = 0; i < 200; i++) begin
            en_q.push_back(1'b1);
            if (i < 69) begin
                case (i % 4)
                    0: smp_q.push_back(10);
                    1: smp_q.push_back(20);
                    2: smp_q.push_back(100);
                    default: smp_q.push_back(20);
                endcase
            end else begin
                smp_q.push_back(((i - 69) % 4 == 3) ? 90 : 0);
            end
        end
        start_extra = '{100};
        run_check("trk1", 2, 1600, 70, 300);
        wait_done("trk2", 300, dc);
        chk("trk2_cycle",  64'(dc),         139);
        chk("trk2_phase",  64'(phase_out),  3);
        chk("trk2_energy", 64'(energy_max), 1440);
        chk("trk2_locked", 64'(locked),     1);
        start_extra.delete();
`else
        repeat (3) @(negedge clk);
        chk("idle_busy", 64'(busy), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_phase_ctrl.md
RX_PHASE_CTRL -- requirements
Module: rx_phase_ctrl

Interface
REQ-001 Parameter UPSAMPLE, default 4: samples per symbol; a power of two, at least 2.
REQ-002 Parameter DATA_NBITS, default 8: width of the signed filter output sample.
REQ-003 Parameter WIN_LOG2, default 10: measurement window is 2^WIN_LOG2 symbols.
REQ-004 Localparam ACC_NBITS = DATA_NBITS + WIN_LOG2, PH_NBITS = $clog2(UPSAMPLE).
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  sample strobe, same as the filter enable; one sample per high cycle.
REQ-008 start  input  1  single-cycle request to begin a measurement.
REQ-009 sample_in  input  DATA_NBITS  signed full-rate matched-filter output, valid when enable=1.
REQ-010 phase_out  output  PH_NBITS  selected sampling phase, drives the filter phase_in.
REQ-011 locked  output  1  high once at least one decision has completed.
REQ-012 busy  output  1  high in MEASURE and DECIDE.
REQ-013 done  output  1  one-cycle pulse when phase_out is updated.
REQ-014 energy_max  output  ACC_NBITS  accumulator value of the winning phase.

Function
REQ-015 FSM states are IDLE, MEASURE, DECIDE and DONE; all outputs are registered.
REQ-016 IDLE -> MEASURE on start=1: clear all UPSAMPLE accumulators, phase counter and symbol counter in that cycle.
REQ-017 start while busy=1 or in DONE: ignored, no restart.
REQ-018 MEASURE with enable=1: acc[phase_cnt] += |sample_in|; phase_cnt increments modulo UPSAMPLE.
REQ-019 MEASURE with enable=0: accumulators and counters hold.
REQ-020 |sample_in| is computed as DATA_NBITS unsigned, so -2^(DATA_NBITS-1) yields 2^(DATA_NBITS-1) with no wrap.
REQ-021 Accumulator saturation: any sum exceeding 2^ACC_NBITS-1 clamps to all-ones.
REQ-022 Symbol counter increments when phase_cnt wraps from UPSAMPLE-1 to 0.
REQ-023 MEASURE -> DECIDE on the cycle that the 2^WIN_LOG2-th symbol completes.
REQ-024 DECIDE scans one accumulator per cycle, index 0 to UPSAMPLE-1, using a strict greater-than compare; ties keep the lower index.
REQ-025 DECIDE lasts exactly UPSAMPLE cycles, then goes to DONE.
REQ-026 DONE lasts 1 cycle: phase_out and energy_max are loaded, done=1, and locked is set.
REQ-027 phase_out changes only in DONE; it holds its value through all later measurements.
REQ-028 Start-to-done latency = 1 + UPSAMPLE*2^WIN_LOG2 enabled cycles + UPSAMPLE + 1 cycles.

Reset
REQ-029 rst=0 forces IDLE: phase_out=0, locked=0, busy=0, done=0, energy_max=0, all accumulators and counters = 0.
REQ-030 Reset mid-MEASURE or mid-DECIDE discards the partial result; it is not resumed.

Configuration
REQ-031 Macro RX_PHASE_CTRL_TRACK_EN selects the post-DONE behaviour.
REQ-032 Macro defined: DONE -> MEASURE with accumulators and counters cleared, continuous re-measurement; start is ignored after the first decision.
REQ-033 Macro undefined: DONE -> IDLE; a new measurement requires start.

Verification (UPSAMPLE=4, DATA_NBITS=8, WIN_LOG2=4)
REQ-034 Reset checks:
- rst low mid-MEASURE -> all outputs and state return to 0/IDLE next cycle.
- After rst high, start -> full window measured from zero.

REQ-035 Phase 2 wins:
- Stimulus: sample_in pattern per symbol {10,20,100,20}, enable=1, start pulse.
- Required response: done at cycle 1+64+4+1=70, phase_out=2, energy_max=1600, locked=1.

REQ-036 Tie:
- Stimulus: pattern {50,50,-50,-50}.
- Required response: phase_out=0, energy_max=800.

REQ-037 Extreme value and enable gaps:
- Stimulus: pattern {-128,0,0,0} with enable toggling every other cycle.
- Required response: phase_out=0, energy_max=2048, done at 1+128+4+1 cycles.

REQ-038 Saturation: with WIN_LOG2=4 and ACC_NBITS=12, force accumulators near the limit -> phase 1 value clamps to 4095 and does not wrap.

REQ-039 Start and mode behaviour:
- start pulses during MEASURE -> ignored, done still at cycle 70.
- Macro defined: a second done 69 cycles later; phase_out follows a pattern change to {0,0,0,90} -> 3.
- Macro undefined: returns to IDLE, busy=0.
